// File: rtl/sum_block_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_block_pkg
// Purpose  : Shared state encoding and sizing helper for the block accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package sum_block_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Minimum counter width able to hold the value COUNT itself.
  function automatic int cnt_width_for(input int count);
    return $clog2(count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sum_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_block_accumulator
// Purpose  : Sums COUNT samples into one block total with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module sum_block_accumulator
  import sum_block_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow
);

  localparam logic [CNT_WIDTH-1:0] C_COUNT = CNT_WIDTH'(COUNT);
  localparam int                   C_PAD   = ACC_WIDTH + 1 - WIDTH;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ovf;
  logic                   r_out_valid;
  logic [ACC_WIDTH-1:0]   r_out_data;
  logic [CNT_WIDTH-1:0]   r_out_count;
  logic                   r_out_overflow;

  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_carry;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic                   w_in_xfer;
  logic                   w_out_xfer;
  logic                   w_emit_sample;
  logic                   w_emit_partial;

  // One extra bit so the carry out of ACC_WIDTH is observable.
  assign w_sum      = {1'b0, r_acc} + {{C_PAD{1'b0}}, in_data};
  assign w_carry    = w_sum[ACC_WIDTH];
  assign w_cnt_inc  = r_cnt + CNT_WIDTH'(1);
  assign w_out_xfer = r_out_valid & out_ready;

  assign in_ready     = (r_state == ST_ACCUM);
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_overflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_in_xfer      = 1'b0;
    w_emit_sample  = 1'b0;
    w_emit_partial = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_in_xfer = in_valid;
        if (in_valid && ((w_cnt_inc == C_COUNT) || flush)) begin
          w_emit_sample = 1'b1;
          w_state_next  = ST_HOLD;
        end else if (!in_valid && flush && (r_cnt != '0)) begin
          // Flush of an empty block is deliberately a no-op.
          w_emit_partial = 1'b1;
          w_state_next   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_out_xfer) begin
          w_state_next = ST_ACCUM;
        end
      end
      default: begin
        w_state_next = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      if (w_emit_sample) begin
        r_out_data     <= w_sum[ACC_WIDTH-1:0];
        r_out_count    <= w_cnt_inc;
        r_out_overflow <= r_ovf | w_carry;
        r_out_valid    <= 1'b1;
        r_acc          <= '0;
        r_cnt          <= '0;
        r_ovf          <= 1'b0;
      end else if (w_in_xfer) begin
        r_acc <= w_sum[ACC_WIDTH-1:0];
        r_cnt <= w_cnt_inc;
        r_ovf <= r_ovf | w_carry;
      end else if (w_emit_partial) begin
        r_out_data     <= r_acc;
        r_out_count    <= r_cnt;
        r_out_overflow <= r_ovf;
        r_out_valid    <= 1'b1;
        r_acc          <= '0;
        r_cnt          <= '0;
        r_ovf          <= 1'b0;
      end
      // Emission only happens in ACCUM, where out_valid is already low.
      if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_block_accumulator
// Purpose  : Self-checking bench: queue-based block model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_block_accumulator;

  localparam int W  = 8;
  localparam int AW = 9;
  localparam int CN = 4;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: samples of the open block, plus the one pending result.
  int q[$];
  bit m_pend = 1'b0;
  int m_data = 0;
  int m_cnt  = 0;
  bit m_ovf  = 1'b0;

  sum_block_accumulator #(
    .WIDTH(W), .ACC_WIDTH(AW), .COUNT(CN), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_overflow(out_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A carry occurs exactly when the true total reaches 2^AW.
  task automatic close_block();
    int total;
    total = 0;
    foreach (q[i]) total += q[i];
    m_data = total % (1 << AW);
    m_ovf  = (total >= (1 << AW));
    m_cnt  = q.size();
    m_pend = 1'b1;
    q.delete();
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (out_ready) m_pend = 1'b0;
    end else if (in_valid) begin
      q.push_back(int'(in_data));
      if (q.size() == CN || flush) close_block();
    end else if (flush && q.size() > 0) begin
      close_block();
    end
  end

  always @(negedge clock) begin
    check("m_in_ready", in_ready, !m_pend);
    check("m_out_valid", out_valid, m_pend);
    if (m_pend) begin
      check("m_out_data", out_data, m_data);
      check("m_out_count", out_count, m_cnt);
      check("m_out_overflow", out_overflow, m_ovf);
    end
    if (reset) begin
      check("rst_out_data", out_data, 0);
      check("rst_out_count", out_count, 0);
      check("rst_out_overflow", out_overflow, 0);
    end
  end

  task automatic send(input int v, input bit f = 1'b0);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = v[W-1:0];
    flush    = f;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed low, sample %0d not accepted", v);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
  endtask

  task automatic check_out(input int d, input int c, input int o);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL result_timeout: out_valid never rose, expected data %0d", d);
    end else begin
      check("res_data", out_data, d);
      check("res_count", out_count, c);
      check("res_overflow", out_overflow, o);
      check("res_in_ready", in_ready, 0);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Nominal block with one bubble afterwards.
    send(3); send(4); send(5); send(6);
    check_out(18, 4, 0);
    check("bubble_end", in_ready, 1);

    // Wraparound and sticky overflow cleared on the following block.
    repeat (4) send(255);
    check_out(508, 4, 1);
    repeat (4) send(1);
    check_out(4, 4, 0);

    // Backpressure: result held, pending sample refused until release.
    out_ready = 1'b0;
    send(10); send(20); send(30); send(40);
    check_out(100, 4, 0);
    in_valid = 1'b1;
    in_data  = 8'd7;
    repeat (5) begin
      @(negedge clock);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 100);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send(7);
    do_flush();
    check_out(7, 1, 0);

    // Flush alone, flush with a sample, flush of an empty block.
    send(2); send(9);
    do_flush();
    check_out(11, 2, 0);
    send(4);
    send(5, 1'b1);
    check_out(9, 2, 0);
    do_flush();
    repeat (3) begin
      @(negedge clock);
      check("empty_flush", out_valid, 0);
    end
    @(posedge clock);
    #1;

    // Asynchronous reset mid-block, then a clean block.
    send(1); send(2); send(3);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) send(1);
    check_out(4, 4, 0);

    // Asynchronous reset drops a pending result.
    out_ready = 1'b0;
    repeat (4) send(5);
    check_out(20, 4, 0);
    #2 reset = 1'b1;
    #1;
    check("hold_rst_valid", out_valid, 0);
    check("hold_rst_data", out_data, 0);
    check("hold_rst_count", out_count, 0);
    check("hold_rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;

    // Adder-stage sums: in0 = 1+i, in1 = 2+i.
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < 4; i++) begin
        send((1 + blk * 4 + i) + (2 + blk * 4 + i));
      end
      check_out(blk == 0 ? 24 : 56, 4, 0);
    end

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
